// File: rtl/branch_resolve_unit.sv
// rtl/branch_resolve_unit.sv - execute-stage branch resolution against the prediction queue head
//
// Purpose:
//   Compares each resolved conditional branch with the head entry of the
//   branch prediction queue. Pops the queue through update/correct, redirects
//   fetch on a mispredict and holds flush for a fixed squash window. Emits a
//   registered predictor-training record and shadows queue occupancy so that
//   protocol errors can be detected.
//
// Optional feature:
//   BRANCH_RESOLVE_STATS_EN - adds saturating branch/mispredict counters
//   (stat_branches, stat_mispredicts).
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   stall                     global pipeline stall, freezes all state
//   pred_load                 fetch pushed a prediction into the queue
//   br_valid/br_taken/br_pc   resolving conditional branch from EX
//   head_prediction           queue head prediction bit
//   head_mispredict_address   queue head alternate-path PC
//   update, correct           queue pop handshake
//   redirect, redirect_pc     one-cycle fetch redirect
//   flush                     squash younger stages
//   train_valid/pc/taken      registered predictor-training record
//   occupancy                 shadow queue occupancy
//   proto_err                 sticky protocol-error flag
//   stat_branches/mispredicts statistics counters (macro only)

module branch_resolve_unit #(
   parameter int QUEUE_DEPTH  = 3,
   parameter int FLUSH_CYCLES = 2,
   localparam int OCC_W       = $clog2(QUEUE_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             pred_load,
   input  logic             br_valid,
   input  logic             br_taken,
   input  logic [15:0]      br_pc,
   input  logic             head_prediction,
   input  logic [15:0]      head_mispredict_address,
   output logic             update,
   output logic             correct,
   output logic             redirect,
   output logic [15:0]      redirect_pc,
   output logic             flush,
   output logic             train_valid,
   output logic [15:0]      train_pc,
   output logic             train_taken,
   output logic [OCC_W-1:0] occupancy,
`ifdef BRANCH_RESOLVE_STATS_EN
   output logic [15:0]      stat_branches,
   output logic [15:0]      stat_mispredicts,
`endif
   output logic             proto_err
);

   localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_MAX   = OCC_W'(QUEUE_DEPTH);
   localparam logic [3:0]       FLUSH_CNT = 4'(FLUSH_CYCLES);

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [3:0]       r_fcnt;
   logic [3:0]       w_fcnt_nxt;
   logic [OCC_W-1:0] r_occ;
   logic [OCC_W-1:0] w_occ_nxt;
   logic             r_proto_err;
   logic             w_err_set;
   logic             r_train_valid;
   logic [15:0]      r_train_pc;
   logic             r_train_taken;

   logic             w_accept;
   logic             w_correct;
   logic             w_redirect;

   // A branch is only resolved against a real (non-empty) queue head while
   // not squashing; rst gating keeps every combinational output low in reset.
   assign w_accept   = ~rst & br_valid & ~stall & (r_state == IDLE) & (r_occ != '0);
   assign w_correct  = w_accept & (br_taken == head_prediction);
   assign w_redirect = w_accept & ~w_correct;

   assign update      = w_accept;
   assign correct     = w_correct;
   assign redirect    = w_redirect;
   assign redirect_pc = w_redirect ? head_mispredict_address : 16'h0000;
   assign flush       = w_redirect | (r_state == FLUSH);

   assign occupancy   = r_occ;
   assign proto_err   = r_proto_err;
   assign train_valid = r_train_valid;
   assign train_pc    = r_train_pc;
   assign train_taken = r_train_taken;

   // Squash-window FSM
   always_comb begin
      w_state_nxt = r_state;
      w_fcnt_nxt  = r_fcnt;
      case (r_state)
         IDLE: begin
            if (w_redirect) begin
               w_state_nxt = FLUSH;
               w_fcnt_nxt  = FLUSH_CNT;
            end
         end
         FLUSH: begin
            if (!stall) begin
               w_fcnt_nxt = r_fcnt - 4'd1;
               if (r_fcnt == 4'd1) begin
                  w_state_nxt = IDLE;
               end
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_fcnt  <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_fcnt  <= w_fcnt_nxt;
      end
   end

   // Occupancy shadow. In FLUSH pred_load comes from wrong-path fetches and
   // is ignored; a mispredict empties the queue, discarding a coincident push.
   always_comb begin
      w_occ_nxt = r_occ;
      w_err_set = 1'b0;
      if (!stall) begin
         if (w_redirect) begin
            w_occ_nxt = '0;
         end else if (r_state == IDLE) begin
            if (br_valid && (r_occ == '0)) begin
               w_err_set = 1'b1;
            end
            if (w_accept) begin
               // Correct pop; a simultaneous push cancels it out.
               if (!pred_load) begin
                  w_occ_nxt = r_occ - OCC_ONE;
               end
            end else if (pred_load) begin
               if (r_occ == OCC_MAX) begin
                  w_err_set = 1'b1;
               end else begin
                  w_occ_nxt = r_occ + OCC_ONE;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_occ       <= '0;
         r_proto_err <= 1'b0;
      end else begin
         r_occ <= w_occ_nxt;
         if (w_err_set) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   // Training record
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_train_valid <= 1'b0;
         r_train_pc    <= 16'h0000;
         r_train_taken <= 1'b0;
      end else if (w_accept) begin
         r_train_valid <= 1'b1;
         r_train_pc    <= br_pc;
         r_train_taken <= br_taken;
      end else if (!stall) begin
         r_train_valid <= 1'b0;
      end
   end

`ifdef BRANCH_RESOLVE_STATS_EN
   logic [15:0] r_stat_branches;
   logic [15:0] r_stat_mispredicts;

   assign stat_branches    = r_stat_branches;
   assign stat_mispredicts = r_stat_mispredicts;

   // accept and redirect already imply ~stall, so the counters freeze under stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stat_branches    <= 16'h0000;
         r_stat_mispredicts <= 16'h0000;
      end else begin
         if (w_accept && (r_stat_branches != 16'hFFFF)) begin
            r_stat_branches <= r_stat_branches + 16'd1;
         end
         if (w_redirect && (r_stat_mispredicts != 16'hFFFF)) begin
            r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
         end
      end
   end
`endif

endmodule
